// File: rtl/kbd_pkg.sv
// kbd_pkg: shared source ids, event codes, arbiter states and round-robin pick
package kbd_pkg;
    localparam logic [1:0] SRC_KEY = 2'd0;
    localparam logic [1:0] SRC_ENC = 2'd1;
    localparam logic [1:0] SRC_PAT = 2'd2;
    localparam logic [7:0] EVT_NONE = 8'h00;
    localparam logic [1:0] PFX_RELEASE = 2'b10;
    localparam logic [1:0] PFX_PRESS = 2'b01;
    localparam logic [1:0] PFX_ENC = 2'b11;
    localparam int STALL_TMO = 256;

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_STALL} arb_state_t;

    // first pending source at or after start, walking key -> enc -> pat
    function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] start);
        logic [1:0] s;
        rr_pick = start;
        for (int i = 2; i >= 0; i--) begin
            s = 2'((int'(start) + i) % 3);
            if (pend[s]) rr_pick = s;
        end
    endfunction
endpackage

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: first-word-fall-through event FIFO with occupancy count
module kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;

    always_ff @(posedge clk)
        if (push) mem[wr] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + AW'(1);
            if (pop) rd <= rd + AW'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end

    assign head = (count != '0) ? mem[rd] : '0;
endmodule

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: round-robin merge of key, encoder and patient-button events
// into one FIFO, with overflow tracking and a registered host interrupt.
module key_event_arbiter
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_req,
    input  logic [7:0]       key_code,
    input  logic             enc_req,
    input  logic [7:0]       enc_code,
    input  logic             pat_req,
    input  logic [7:0]       pat_code,
    output logic             key_ack,
    output logic             enc_ack,
    output logic             pat_ack,
    output logic             evt_valid,
    output logic [7:0]       evt_code,
    input  logic             evt_ready,
    output logic             evt_irq,
    output logic [CNT_W-1:0] evt_count,
    output logic             ovf_flag,
    input  logic             ovf_clr
);
    logic [2:0] pend, pend_nxt, req, keep, load, ack;
    logic [7:0] codes [3];
    logic [7:0] in_code [3];
    logic [1:0] rr, sel;
    arb_state_t state;
    logic [7:0] tmo;
    logic push_v;
    logic [7:0] push_data;
    logic pop, grant, space, stall, fire, ovf, irq;
    logic [CNT_W-1:0] occ;

    assign in_code = '{key_code, enc_code, pat_code};

    // space accounts for the entry already in flight to the FIFO
    always_comb begin
        req = {pat_req && pat_code != EVT_NONE, enc_req && enc_code != EVT_NONE,
               key_req && key_code != EVT_NONE};
        pop = evt_valid && evt_ready;
        occ = evt_count + CNT_W'(push_v) - CNT_W'(pop);
        space = occ < CNT_W'(FIFO_DEPTH);
        sel = rr_pick(pend, rr);
        grant = |pend && space;
        stall = |pend && !space;
        fire = stall && state == ST_STALL && tmo == 8'(STALL_TMO - 1);
        keep = fire ? 3'b000 : pend & ~(grant ? 3'b001 << sel : 3'b000);
        load = req & ~keep;
        pend_nxt = keep | req;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pend <= '0;
            codes <= '{default: '0};
            rr <= SRC_KEY;
            state <= ST_IDLE;
            tmo <= '0;
            ack <= '0;
            push_v <= 1'b0;
            push_data <= '0;
            ovf <= 1'b0;
            irq <= 1'b0;
        end else begin
            pend <= pend_nxt;
            for (int i = 0; i < 3; i++)
                if (load[i]) codes[i] <= in_code[i];
            ack <= grant ? 3'b001 << sel : 3'b000;
            push_v <= grant;
            if (grant) begin
                push_data <= codes[sel];
                rr <= (sel == SRC_PAT) ? SRC_KEY : sel + 2'd1;
            end
            state <= !(|pend) ? ST_IDLE : space ? ST_GRANT : ST_STALL;
            tmo <= (stall && !fire) ? tmo + 8'd1 : 8'd0;
            ovf <= (|(req & keep)) || fire || (ovf && !ovf_clr);
            irq <= evt_count != '0;
        end

    kbd_event_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .CNT_W(CNT_W)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push_v),
        .din(push_data),
        .pop(pop),
        .head(evt_code),
        .count(evt_count)
    );

    assign evt_valid = evt_count != '0;
    assign key_ack = ack[SRC_KEY];
    assign enc_ack = ack[SRC_ENC];
    assign pat_ack = ack[SRC_PAT];
    assign ovf_flag = ovf;
    assign evt_irq = irq;
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: directed vectors with hand-computed expectations
module tb_key_event_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_req = 1'b0, enc_req = 1'b0, pat_req = 1'b0;
    logic [7:0] key_code = 8'h00, enc_code = 8'h00, pat_code = 8'h00;
    logic key_ack, enc_ack, pat_ack, evt_valid, evt_irq, ovf_flag;
    logic [7:0] evt_code;
    logic evt_ready = 1'b0, ovf_clr = 1'b0;
    logic [3:0] evt_count;
    int total = 0, bad = 0;
    int kc = 0, ec = 0, pc = 0;
    int k0, e0, p0;
    bit seen;

    key_event_arbiter #(.FIFO_DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_req(key_req), .key_code(key_code),
        .enc_req(enc_req), .enc_code(enc_code),
        .pat_req(pat_req), .pat_code(pat_code),
        .key_ack(key_ack), .enc_ack(enc_ack), .pat_ack(pat_ack),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
        .evt_irq(evt_irq), .evt_count(evt_count),
        .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        kc += int'(key_ack);
        ec += int'(enc_ack);
        pc += int'(pat_ack);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pop1();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 8'h00);
        check("rst_count", evt_count, 0);
        check("rst_irq", evt_irq, 0);
        check("rst_ovf", ovf_flag, 0);
        check("rst_acks", {pat_ack, enc_ack, key_ack}, 0);
        rst_n = 1'b1;
        tick();

        // single event
        key_req = 1'b1; key_code = 8'h45;
        tick();
        key_req = 1'b0;
        check("single_ack_early", key_ack, 0);
        tick();
        check("single_ack", key_ack, 1);
        check("single_valid_early", evt_valid, 0);
        tick();
        check("single_ack_pulse", key_ack, 0);
        check("single_valid", evt_valid, 1);
        check("single_code", evt_code, 8'h45);
        check("single_irq_early", evt_irq, 0);
        tick();
        check("single_irq", evt_irq, 1);

        // simultaneous events, from a reset round-robin pointer
        do_reset();
        key_req = 1'b1; key_code = 8'h41;
        enc_req = 1'b1; enc_code = 8'hC0;
        pat_req = 1'b1; pat_code = 8'h82;
        tick();
        key_req = 1'b0; enc_req = 1'b0; pat_req = 1'b0;
        tick();
        check("sim_ack1", {pat_ack, enc_ack, key_ack}, 3'b001);
        tick();
        check("sim_ack2", {pat_ack, enc_ack, key_ack}, 3'b010);
        tick();
        check("sim_ack3", {pat_ack, enc_ack, key_ack}, 3'b100);
        tick();
        check("sim_ack_done", {pat_ack, enc_ack, key_ack}, 3'b000);
        check("sim_count", evt_count, 3);
        check("sim_head1", evt_code, 8'h41);
        pop1();
        check("sim_head2", evt_code, 8'hC0);
        pop1();
        check("sim_head3", evt_code, 8'h82);
        pop1();
        check("sim_empty", evt_valid, 0);
        tick();
        check("sim_irq_fall", evt_irq, 0);

        // code 00 is ignored
        k0 = kc;
        key_req = 1'b1; key_code = 8'h00;
        tick();
        key_req = 1'b0;
        repeat (3) tick();
        check("zero_code_ack", kc - k0, 0);
        check("zero_code_count", evt_count, 0);

        // fill the FIFO with back-to-back key events 1..8
        for (int i = 1; i <= 8; i++) begin
            key_req = 1'b1; key_code = 8'(i);
            tick();
        end
        key_req = 1'b0;
        repeat (4) tick();
        check("full_count", evt_count, 8);
        check("full_no_ovf", ovf_flag, 0);
        e0 = ec;
        enc_req = 1'b1; enc_code = 8'hC3;
        tick();
        enc_req = 1'b0;
        repeat (5) tick();
        check("full_no_ack", ec - e0, 0);
        check("full_count_hold", evt_count, 8);
        check("full_head", evt_code, 8'h01);
        pop1();
        repeat (3) tick();
        check("full_ack_after_pop", ec - e0, 1);
        check("full_count_refill", evt_count, 8);

        // back-to-back key while full: second one dropped
        k0 = kc; p0 = pc;
        key_req = 1'b1; key_code = 8'h47;
        tick();
        key_code = 8'h48;
        tick();
        key_req = 1'b0;
        check("b2b_ovf", ovf_flag, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("b2b_ovf_clr", ovf_flag, 0);

        // stall timeout with pat pending
        pat_req = 1'b1; pat_code = 8'h82;
        tick();
        pat_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = ovf_flag;
        end
        check("tmo_ovf", seen, 1);
        check("tmo_no_pat_ack", pc - p0, 0);
        check("tmo_no_key_ack", kc - k0, 0);
        pop1();
        repeat (4) tick();
        check("tmo_pending_cleared", evt_count, 7);
        check("tmo_no_ack_after_pop", (pc - p0) + (kc - k0), 0);

        // reset mid-operation with 5 queued and one pending
        pop1();
        pop1();
        check("rst5_count_before", evt_count, 5);
        e0 = ec; k0 = kc; p0 = pc;
        enc_req = 1'b1; enc_code = 8'h11;
        tick();
        enc_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst5_valid", evt_valid, 0);
        check("rst5_count", evt_count, 0);
        check("rst5_ovf", ovf_flag, 0);
        check("rst5_irq", evt_irq, 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("rst5_no_ack", (ec - e0) + (kc - k0) + (pc - p0), 0);
        check("rst5_still_empty", evt_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- FIFO_DEPTH, 8: event FIFO entries; power of two, 4..16.
- CNT_W, 4: occupancy width; equals log2(FIFO_DEPTH)+1.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- key_req, in, 1: key-scanner event strobe.
- key_code, in, 8: key event code.
- enc_req, in, 1: encoder event strobe.
- enc_code, in, 8: encoder event code.
- pat_req, in, 1: patient-button event strobe.
- pat_code, in, 8: patient-button event code.
- key_ack, out, 1: key event accepted into the FIFO.
- enc_ack, out, 1: encoder event accepted into the FIFO.
- pat_ack, out, 1: patient-button event accepted into the FIFO.
- evt_valid, out, 1: FIFO head valid.
- evt_code, out, 8: FIFO head code.
- evt_ready, in, 1: consumer pops the head.
- evt_irq, out, 1: host interrupt request.
- evt_count, out, CNT_W: FIFO occupancy.
- ovf_flag, out, 1: sticky lost-event flag.
- ovf_clr, in, 1: clears ovf_flag.

Function
REQ-003 Each *_req SHALL be sampled every clk; req=1 with code != 8'h00 SHALL set that source's pending bit and latch its code on the same edge. A code of 8'h00 SHALL be ignored.
REQ-004 A req arriving while its source's pending bit is set SHALL be dropped (the latched code is kept) and SHALL set ovf_flag.
REQ-005 The arbiter SHALL move at most one pending entry per cycle into the FIFO. Grant order SHALL be round-robin key -> enc -> pat, starting after the last granted source.
REQ-006 On a grant, the pending bit SHALL clear and the matching *_ack SHALL pulse for exactly 1 cycle on the following cycle. A new req in the grant cycle SHALL re-set pending (it is not an overflow).
REQ-007 A grant SHALL occur only when evt_count < FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise pending entries SHALL wait, not drop.
REQ-008 The FIFO SHALL be first-word-fall-through: evt_valid = (evt_count != 0) and evt_code = head. A pop SHALL occur when evt_valid & evt_ready. evt_ready with an empty FIFO SHALL have no effect.
REQ-009 Latency from a req edge (idle arbiter, empty FIFO) to evt_valid=1 SHALL be 2 clk.
REQ-010 Push and pop in the same cycle SHALL leave evt_count unchanged. Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-011 evt_irq SHALL be a registered signal. It SHALL rise the cycle after evt_count goes 0->nonzero, and SHALL fall the cycle after the FIFO empties.
REQ-012 ovf_flag SHALL also be set when the FIFO stays full for 256 consecutive cycles while any pending bit is set; the stale pending entries SHALL then be discarded.
REQ-013 ovf_clr SHALL clear ovf_flag. A set event in the same cycle SHALL win.
REQ-014 Arbiter states SHALL be IDLE (no pending), GRANT (pending and space available), STALL (pending and FIFO full). Transitions SHALL be evaluated every cycle, and STALL SHALL count the REQ-012 timeout.

Reset
REQ-015 rst_n=0 SHALL asynchronously clear all of the following: pending bits, latched codes, FIFO pointers, timeout counter, round-robin pointer (to key), and state (IDLE).
REQ-016 Reset values SHALL be: all *_ack=0, evt_valid=0, evt_code=8'h00, evt_irq=0, evt_count=0, ovf_flag=0.
REQ-017 Reset asserted mid-operation SHALL discard all queued and pending events. No ack SHALL be issued after reset.

Structure
REQ-018 Package kbd_pkg SHALL hold:
- SRC_KEY=0, SRC_ENC=1, SRC_PAT=2;
- EVT_NONE=8'h00;
- event prefixes PFX_RELEASE=2'b10, PFX_PRESS=2'b01, PFX_ENC=2'b11;
- the arbiter state encoding;
- the stall timeout constant 256.
REQ-019 The FIFO SHALL be a sub-module, kbd_event_fifo, parameterised by depth and width. All arbitration SHALL stay in key_event_arbiter.

Verification
REQ-020 Single event: key_req=1 with code 8'h45, evt_ready=0 -> key_ack pulses at cycle+1, evt_valid=1 and evt_code=8'h45 at cycle+2, evt_irq=1 at cycle+3.
REQ-021 Simultaneous events: key=8'h41, enc=8'hC0, pat=8'h82 in the same cycle -> FIFO order 41, C0, 82, with acks on 3 consecutive cycles.
REQ-022 Full FIFO: 8 events queued, evt_ready=0, then enc_req with code 8'hC3 -> no enc_ack. After one pop, C3 is accepted and evt_count stays 8.
REQ-023 Back-to-back req: key_req twice (8'h47 then 8'h48) while the FIFO is full -> 8'h48 is dropped and ovf_flag=1. ovf_clr=1 -> ovf_flag=0 on the next cycle.
REQ-024 Reset: rst_n low for 1 cycle with 5 queued events -> evt_valid=0 and evt_count=0 immediately, and no ack follows.
REQ-025 Stall timeout: FIFO full with pat pending for 256 cycles -> ovf_flag=1, pending cleared, and no pat_ack.
